// File: rtl/uart_link.sv
// uart_link: full-duplex UART with configurable parity and a first-word fall-through RX FIFO.
module uart_link #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 5208,
  parameter int PARITY = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic                          tx,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam bit ODD = (PARITY == 2);
  localparam bit HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [IW-1:0] tx_idx;
  logic [DATA_W-1:0] tx_shift;
  logic tx_par, tx_tick;

  assign tx_tick = tx_cnt == DIV_END;
  assign tx_ready = tx_state == S_IDLE;
  assign tx = tx_state == S_START ? 1'b0 :
              tx_state == S_DATA ? tx_shift[0] :
              tx_state == S_PARITY ? tx_par : 1'b1;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_valid) tx_next = S_START;
      S_START:  if (tx_tick) tx_next = S_DATA;
      S_DATA:   if (tx_tick && tx_idx == LAST_BIT) tx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_next = S_STOP;
      S_STOP:   if (tx_tick) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_shift <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_cnt <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_valid && tx_ready) begin
        tx_shift <= tx_data;
        tx_idx <= '0;
        tx_par <= ^tx_data ^ ODD;
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end

  state_t rx_state, rx_next;
  logic rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [IW-1:0] rx_idx;
  logic [DATA_W-1:0] rx_shift;
  logic rx_par, rx_tick, stop_tick, par_bad, rx_push;

  // START times out at mid-bit; every later bit is a full period after that.
  assign rx_tick = rx_cnt == (rx_state == S_START ? HALF_END : DIV_END);
  assign stop_tick = rx_tick && rx_state == S_STOP;
  assign par_bad = HAS_PAR && (rx_par != (^rx_shift ^ ODD));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_prev && !rx_s2) rx_next = S_START;
      S_START:  if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_idx == LAST_BIT) rx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_next = S_STOP;
      S_STOP:   if (rx_tick) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  // A low line after a framing error produces no new edge, so re-arm waits for idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_shift <= '0;
      rx_par <= 1'b0;
      rx_push <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_state <= rx_next;
      rx_cnt <= (rx_state == S_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_state == S_START) rx_idx <= '0;
      else if (rx_state == S_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
        rx_idx <= rx_idx + 1'b1;
      end
      if (rx_state == S_PARITY && rx_tick) rx_par <= rx_s2;
      rx_push <= stop_tick && rx_s2 && !par_bad;
      rx_frame_err <= stop_tick && !rx_s2;
      rx_parity_err <= stop_tick && rx_s2 && par_bad;
    end
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, pop, wr;

  assign full = rx_count == FULL_CNT;
  assign pop = rx_valid && rx_ready;
  assign wr = rx_push && (!full || pop);
  assign rx_overrun = rx_push && full && !pop;
  assign rx_valid = rx_count != '0;
  assign rx_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      rx_count <= rx_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rx_shift;
  end
endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: three DUTs (no/even/odd parity) checked against a frame-level model and a FIFO scoreboard.
module tb_uart_link;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] tx, tx_ready, tx_valid, rx_drv, loop, rx_valid, rx_ready, ovr, ferr, perr;
  logic [7:0] tx_data [3];
  logic [7:0] rx_data [3];
  logic [2:0] rx_count [3];
  int vectors = 0;
  int miscompares = 0;
  int ferr_n [3];
  int perr_n [3];
  int ovr_n [3];
  int exp_f [3];
  int exp_p [3];
  int exp_o [3];
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic rx_in;
    assign rx_in = loop[g] ? tx[g] : rx_drv[g];
    uart_link #(.DATA_W(8), .CLK_DIV(4), .PARITY(g), .FIFO_DEPTH(4)) u (
      .clk(clk), .reset(reset), .rx(rx_in), .tx(tx[g]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .rx_count(rx_count[g]), .rx_overrun(ovr[g]),
      .rx_frame_err(ferr[g]), .rx_parity_err(perr[g]));
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ferr_n[i] += int'(ferr[i]);
      perr_n[i] += int'(perr[i]);
      ovr_n[i] += int'(ovr[i]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int flen(int p);
    return (p != 0) ? 11 : 10;
  endfunction

  function automatic logic [10:0] frame(int p, logic [7:0] d, bit bad_par, bit bad_stop);
    logic [10:0] f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (p != 0) f[9] = ((p == 1) ? ^d : ~^d) ^ bad_par;
    f[flen(p)-1] = ~bad_stop;
    return f;
  endfunction

  task automatic send_tx(int p, logic [7:0] d);
    logic [10:0] f = frame(p, d, 1'b0, 1'b0);
    int bad = 0;
    int busy = 0;
    @(negedge clk);
    chk("tx_ready_idle", tx_ready[p], 1);
    tx_data[p] = d;
    tx_valid[p] = 1'b1;
    @(posedge clk);
    #1 tx_valid[p] = 1'b0;
    tx_data[p] = 8'($urandom);
    for (int k = 0; k < 4 * flen(p); k++) begin
      @(negedge clk);
      if (tx[p] !== f[k/4]) bad++;
      if (tx_ready[p] === 1'b0) busy++;
      if (k == 8) begin
        tx_valid[p] = 1'b1;
        tx_data[p] = 8'($urandom);
      end
      if (k == 24) tx_valid[p] = 1'b0;
    end
    chk("tx_wave", bad, 0);
    chk("tx_busy_cycles", busy, 4 * flen(p));
    @(negedge clk);
    chk("tx_ready_return", tx_ready[p], 1);
  endtask

  task automatic check_rx(int p);
    chk("rx_count", rx_count[p], sb.size());
    chk("rx_valid", rx_valid[p], sb.size() != 0);
    if (sb.size() != 0) chk("rx_head", rx_data[p], sb[0]);
    chk("frame_err_pulses", ferr_n[p], exp_f[p]);
    chk("parity_err_pulses", perr_n[p], exp_p[p]);
    chk("overrun_pulses", ovr_n[p], exp_o[p]);
  endtask

  // kind: 0 good, 1 corrupt parity, 2 stop bit forced low
  task automatic rx_frame(int p, logic [7:0] d, int kind, bit pop);
    logic [10:0] f = frame(p, d, kind == 1, kind == 2);
    for (int k = 0; k < 4 * flen(p); k++) begin
      @(negedge clk);
      rx_drv[p] = f[k/4];
    end
    if (kind == 2) repeat (6) @(negedge clk);
    @(negedge clk);
    rx_drv[p] = 1'b1;
    if (pop) begin
      @(posedge clk);
      #1 rx_ready[p] = 1'b1;
      @(posedge clk);
      #1 rx_ready[p] = 1'b0;
    end
    repeat (10) @(negedge clk);
    if (pop && sb.size() != 0) void'(sb.pop_front());
    if (kind == 2) exp_f[p]++;
    else if (kind == 1) exp_p[p]++;
    else if (sb.size() < 4) sb.push_back(d);
    else exp_o[p]++;
    check_rx(p);
  endtask

  task automatic pop_one(int p);
    @(negedge clk);
    chk("pop_valid", rx_valid[p], sb.size() != 0);
    if (sb.size() != 0) chk("pop_data", rx_data[p], sb[0]);
    rx_ready[p] = 1'b1;
    @(posedge clk);
    #1 rx_ready[p] = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    chk("pop_count", rx_count[p], sb.size());
  endtask

  task automatic drain(int p);
    while (sb.size() != 0) pop_one(p);
    pop_one(p);
  endtask

  initial begin
    logic [7:0] d;
    int kind;
    bit pop;
    tx_valid = '0;
    rx_drv = '1;
    loop = '0;
    rx_ready = '0;
    for (int i = 0; i < 3; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx", tx[i], 1);
      chk("reset_tx_ready", tx_ready[i], 1);
      chk("reset_rx_valid", rx_valid[i], 0);
      chk("reset_rx_count", rx_count[i], 0);
      chk("reset_err", {ovr[i], ferr[i], perr[i]}, 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_tx(0, 8'hA5);

    loop[1] = 1'b1;
    send_tx(1, 8'h3C);
    repeat (12) @(negedge clk);
    sb.push_back(8'h3C);
    check_rx(1);
    pop_one(1);
    loop[1] = 1'b0;

    rx_frame(2, 8'h55, 1, 1'b0);

    @(negedge clk);
    rx_drv[0] = 1'b0;
    @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (16) @(negedge clk);
    check_rx(0);
    rx_frame(0, 8'h96, 0, 1'b0);
    rx_frame(0, 8'h81, 2, 1'b0);
    rx_frame(0, 8'h7E, 0, 1'b0);
    drain(0);

    for (int n = 0; n < 5; n++) rx_frame(1, 8'($urandom), 0, 1'b0);
    rx_frame(1, 8'($urandom), 0, 1'b1);
    drain(1);

    @(negedge clk);
    chk("abort_pre_ready", tx_ready[0], 1);
    tx_data[0] = 8'hC3;
    tx_valid[0] = 1'b1;
    rx_drv[2] = 1'b0;
    @(posedge clk);
    #1 tx_valid[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("abort_mid_bit3", tx[0], 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx[0], 1);
    chk("abort_tx_ready", tx_ready[0], 1);
    reset = 1'b0;
    rx_drv[2] = 1'b1;
    send_tx(0, 8'h0F);
    repeat (20) @(negedge clk);
    check_rx(2);

    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 12; n++) begin
        d = 8'($urandom);
        kind = int'($urandom_range(0, 3));
        if (kind == 3 || (p == 0 && kind == 1)) kind = 0;
        pop = (kind == 0) && ($urandom_range(0, 3) == 0);
        fork
          send_tx(p, 8'($urandom));
          rx_frame(p, d, kind, pop);
        join
        if ($urandom_range(0, 1) == 1) pop_one(p);
      end
      drain(p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter CLK_DIV, default 5208, clk cycles per bit (>=4).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, RX FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port rx  in  1  asynchronous serial input, idle high.
REQ-008 SHALL have port tx  out  1  serial output, idle high.
REQ-009 SHALL have port tx_data  in  DATA_W  byte to send.
REQ-010 SHALL have port tx_valid  in  1  send request.
REQ-011 SHALL have port tx_ready  out  1  transmitter idle, can accept.
REQ-012 SHALL have port rx_data  out  DATA_W  RX FIFO head (first-word fall-through).
REQ-013 SHALL have port rx_valid  out  1  RX FIFO non-empty.
REQ-014 SHALL have port rx_ready  in  1  pop RX FIFO head.
REQ-015 SHALL have port rx_count  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
REQ-016 SHALL have ports rx_overrun, rx_frame_err, rx_parity_err  out  1 each  one-cycle error pulses.

Function
REQ-017 Frame SHALL be: start (0), DATA_W bits LSB first, parity bit if PARITY!=0, one stop (1).
REQ-018 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-019 Handshake tx_valid&&tx_ready SHALL latch tx_data and enter START; tx low from the next cycle.
REQ-020 Each TX bit SHALL be held exactly CLK_DIV cycles; tx_ready returns 1 on the cycle after STOP completes.
REQ-021 tx_valid while tx_ready=0 SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-022 rx SHALL pass a 2-flop synchronizer before use.
REQ-023 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronized high-to-low.
REQ-024 START SHALL resample at CLK_DIV/2; if high, false start, return to IDLE with no push or error.
REQ-025 Data, parity, stop bits SHALL each be sampled at CLK_DIV intervals after the mid-start sample.
REQ-026 Parity mismatch SHALL drop the word and pulse rx_parity_err one cycle after the stop sample.
REQ-027 Stop sampled 0 SHALL drop the word, pulse rx_frame_err, and re-arm only after rx seen high.
REQ-028 Valid word SHALL push the FIFO one cycle after the stop sample; rx_valid rises the following cycle.
REQ-029 Push when full and no simultaneous pop SHALL drop the new word (FIFO unchanged) and pulse rx_overrun.
REQ-030 Simultaneous push and pop when full SHALL both succeed; rx_count unchanged, no overrun.
REQ-031 Pop SHALL occur only on rx_valid&&rx_ready; rx_ready while empty SHALL be ignored.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; rx_count ranges 0..FIFO_DEPTH.
REQ-033 Parity: even = XOR of data bits; odd = its inverse.
REQ-034 TX and RX SHALL operate concurrently and independently (full duplex).

Reset
REQ-035 Reset SHALL force tx=1, tx_ready=1, rx_valid=0, rx_count=0, all error pulses 0, both FSMs IDLE, divider counters 0.
REQ-036 Reset mid-frame SHALL abort both directions; tx high on the cycle after reset is sampled; partial RX word discarded.
REQ-037 FIFO contents after reset SHALL be don't-care; rx_data is valid only when rx_valid=1.

Verification (CLK_DIV=4, DATA_W=8, FIFO_DEPTH=4)
REQ-038 TX 0xA5, PARITY=0: tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_ready low for 40 cycles.
REQ-039 Loopback tx->rx of 0x3C, PARITY=1: rx_valid rises, rx_data=0x3C, rx_count=1; pop -> rx_count=0.
REQ-040 RX 0x55 with bad parity (PARITY=2): rx_parity_err one pulse, rx_count stays 0.
REQ-041 RX 5 words, no pops: first 4 stored in order, 5th drops, rx_overrun one pulse, rx_count=4.
REQ-042 rx low for 1 cycle only: no push, no error, RX FSM back in IDLE; stop bit forced 0: rx_frame_err pulse.
REQ-043 Reset asserted during TX DATA bit 3: tx=1, tx_ready=1 next cycle; new 0x0F frame sends correctly.
